// File: rtl/seq_pattern_scheduler_pkg.sv
// Shared definitions for the sequencer pattern scheduler.
// Contents: CPU register map, CTRL bit positions, config-strobe FSM state
// encoding, config kind select, and the STATUS word layout.
package seq_pattern_scheduler_pkg;

  localparam int ADDR_CTRL   = 8;
  localparam int ADDR_LEN    = 9;
  localparam int ADDR_TEMPO  = 10;
  localparam int ADDR_PITCH  = 11;
  localparam int ADDR_STATUS = 12;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_LOOP_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } strobe_state_e;

  typedef enum logic {
    KIND_TEMPO = 1'b0,
    KIND_PITCH = 1'b1
  } cfg_kind_e;

  // STATUS = {run, idx[2:0], pend_t, pend_p, busy, 0}
  function automatic logic [7:0] pack_status(input logic       run,
                                             input logic [2:0] idx,
                                             input logic       pend_t,
                                             input logic       pend_p,
                                             input logic       busy);
    return {run, idx, pend_t, pend_p, busy, 1'b0};
  endfunction

endpackage

// File: rtl/seq_pattern_scheduler_if.sv
// CPU register bus of the pattern scheduler.
// sel/we/addr/data_in driven by the CPU (master); data_out returned by the
// scheduler (slave), registered and valid the cycle after a read access.
interface seq_pattern_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, output we, output addr, output data_in, input data_out);
  modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface

// File: rtl/seq_pattern_scheduler_cfg_strobe_fsm.sv
// Tempo/pitch update serialiser for the shared freqin code bus.
// Ports: clk, rst (async, active-high); tempo_wr/pitch_wr + wdata from CPU
// decode; tempo/pitch shadow values (for readback); pend_t/pend_p/busy status;
// cfg_code, sel_loop, sel_snd towards the loop controller (all registered).
module seq_pattern_scheduler_cfg_strobe_fsm
  import seq_pattern_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tempo_wr,
  input  logic       pitch_wr,
  input  logic [3:0] wdata,
  output logic [2:0] tempo,
  output logic [3:0] pitch,
  output logic       pend_t,
  output logic       pend_p,
  output logic       busy,
  output logic [7:0] cfg_code,
  output logic       sel_loop,
  output logic       sel_snd
);

  strobe_state_e state_q, state_d;
  cfg_kind_e     kind_q, kind_d;
  logic [2:0]    tempo_q, tempo_d;
  logic [3:0]    pitch_q, pitch_d;
  logic          pend_t_q, pend_t_d;
  logic          pend_p_q, pend_p_d;
  logic [7:0]    cfg_code_q, cfg_code_d;
  logic          sel_loop_q, sel_loop_d;
  logic          sel_snd_q, sel_snd_d;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    tempo_d    = tempo_q;
    pitch_d    = pitch_q;
    pend_t_d   = pend_t_q;
    pend_p_d   = pend_p_q;
    cfg_code_d = cfg_code_q;
    sel_loop_d = 1'b0;
    sel_snd_d  = 1'b0;

    if (tempo_wr) tempo_d = wdata[2:0];
    if (pitch_wr) pitch_d = wdata[3:0];

    case (state_q)
      // The code is taken from the *_d shadow so a write landing in the
      // pick cycle is still part of this update (latest value wins).
      ST_IDLE: begin
        if (pend_t_q) begin
          kind_d     = KIND_TEMPO;
          cfg_code_d = {5'b0, tempo_d};
          state_d    = ST_SETUP;
        end else if (pend_p_q) begin
          kind_d     = KIND_PITCH;
          cfg_code_d = {4'b0, pitch_d};
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d    = ST_STROBE;
        sel_loop_d = (kind_q == KIND_TEMPO);
        sel_snd_d  = (kind_q == KIND_PITCH);
        if (kind_q == KIND_TEMPO) pend_t_d = 1'b0;
        else                      pend_p_d = 1'b0;
      end
      ST_STROBE: state_d = ST_HOLD;
      default:   state_d = ST_IDLE;
    endcase

    // A write from SETUP onwards re-arms its flag for a fresh update cycle.
    if (tempo_wr) pend_t_d = 1'b1;
    if (pitch_wr) pend_p_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_TEMPO;
      tempo_q    <= '0;
      pitch_q    <= '0;
      pend_t_q   <= 1'b0;
      pend_p_q   <= 1'b0;
      cfg_code_q <= '0;
      sel_loop_q <= 1'b0;
      sel_snd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      tempo_q    <= tempo_d;
      pitch_q    <= pitch_d;
      pend_t_q   <= pend_t_d;
      pend_p_q   <= pend_p_d;
      cfg_code_q <= cfg_code_d;
      sel_loop_q <= sel_loop_d;
      sel_snd_q  <= sel_snd_d;
    end
  end

  assign tempo    = tempo_q;
  assign pitch    = pitch_q;
  assign pend_t   = pend_t_q;
  assign pend_p   = pend_p_q;
  assign busy     = (state_q != ST_IDLE) | pend_t_q | pend_p_q;
  assign cfg_code = cfg_code_q;
  assign sel_loop = sel_loop_q;
  assign sel_snd  = sel_snd_q;

endmodule

// File: rtl/seq_pattern_scheduler.sv
// Sequencer pattern scheduler: pattern register file, bar-tick playback
// index, CPU register decode/readback, and the tempo/pitch strobe serialiser.
// Ports: clk, rst (async, active-high); bus (CPU register slave); bar_tick;
// pattern_out (step mask to kbd_in); cfg_code (freqin); sel_loop/sel_snd
// strobes; busy (update in flight or pending).
module seq_pattern_scheduler
  import seq_pattern_scheduler_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_pattern_scheduler_if.slave  bus,
  input  logic                    bar_tick,
  output logic [7:0]              pattern_out,
  output logic [7:0]              cfg_code,
  output logic                    sel_loop,
  output logic                    sel_snd,
  output logic                    busy
);

  localparam int SW = $clog2(N_SLOTS);
  localparam logic [ADDR_W-1:0] A_LAST_PAT = ADDR_W'(N_SLOTS - 1);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_LEN      = ADDR_W'(ADDR_LEN);
  localparam logic [ADDR_W-1:0] A_TEMPO    = ADDR_W'(ADDR_TEMPO);
  localparam logic [ADDR_W-1:0] A_PITCH    = ADDR_W'(ADDR_PITCH);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(ADDR_STATUS);

  logic [DATA_W-1:0] pat_q [N_SLOTS];
  logic [DATA_W-1:0] pat_d [N_SLOTS];
  logic              run_q, run_d;
  logic              loop_q, loop_d;
  logic [SW-1:0]     len_q, len_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic [7:0]        pattern_out_q, pattern_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic       wr, rd, pat_sel, ctrl_wr, tempo_wr, pitch_wr;
  logic [2:0] tempo;
  logic [3:0] pitch;
  logic       pend_t, pend_p;

  assign wr       = bus.sel & bus.we;
  assign rd       = bus.sel & ~bus.we;
  assign pat_sel  = (bus.addr <= A_LAST_PAT);
  assign ctrl_wr  = wr & (bus.addr == A_CTRL);
  assign tempo_wr = wr & (bus.addr == A_TEMPO);
  assign pitch_wr = wr & (bus.addr == A_PITCH);

  seq_pattern_scheduler_cfg_strobe_fsm u_cfg_strobe (
    .clk      (clk),
    .rst      (rst),
    .tempo_wr (tempo_wr),
    .pitch_wr (pitch_wr),
    .wdata    (bus.data_in[3:0]),
    .tempo    (tempo),
    .pitch    (pitch),
    .pend_t   (pend_t),
    .pend_p   (pend_p),
    .busy     (busy),
    .cfg_code (cfg_code),
    .sel_loop (sel_loop),
    .sel_snd  (sel_snd)
  );

  always_comb begin
    pat_d      = pat_q;
    run_d      = run_q;
    loop_d     = loop_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;

    if (wr && pat_sel)                  pat_d[bus.addr[SW-1:0]] = bus.data_in;
    if (wr && (bus.addr == A_LEN))      len_d = bus.data_in[SW-1:0];

    // A CTRL write owns the index this cycle; a coincident bar_tick is lost.
    if (ctrl_wr) begin
      run_d  = bus.data_in[CTRL_RUN_BIT];
      loop_d = bus.data_in[CTRL_LOOP_BIT];
      if (bus.data_in[CTRL_RUN_BIT] && !run_q) idx_d = '0;
    end else if (bar_tick && run_q) begin
      // >= so that a LEN shrunk below the index wraps on the next tick.
      if (idx_q < len_q) begin
        idx_d = idx_q + SW'(1);
      end else begin
        idx_d = '0;
        if (!loop_q) run_d = 1'b0;
      end
    end

    pattern_out_d = run_q ? pat_q[idx_q][7:0] : 8'h00;

    if (rd) begin
      if (pat_sel) begin
        data_out_d = pat_q[bus.addr[SW-1:0]];
      end else begin
        case (bus.addr)
          A_CTRL:   data_out_d = DATA_W'({6'b0, loop_q, run_q});
          A_LEN:    data_out_d = DATA_W'(len_q);
          A_TEMPO:  data_out_d = DATA_W'(tempo);
          A_PITCH:  data_out_d = DATA_W'(pitch);
          A_STATUS: data_out_d = DATA_W'(pack_status(run_q, 3'(idx_q), pend_t, pend_p, busy));
          default:  data_out_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) pat_q[i] <= '0;
      run_q         <= 1'b0;
      loop_q        <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      pattern_out_q <= '0;
      data_out_q    <= '0;
    end else begin
      pat_q         <= pat_d;
      run_q         <= run_d;
      loop_q        <= loop_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      pattern_out_q <= pattern_out_d;
      data_out_q    <= data_out_d;
    end
  end

  assign pattern_out  = pattern_out_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_seq_pattern_scheduler.sv
module tb_seq_pattern_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       b_sel = 1'b0;
  logic       b_we = 1'b0;
  logic [3:0] b_addr = 4'h0;
  logic [7:0] b_din = 8'h00;
  logic [7:0] pattern_out, cfg_code;
  logic       sel_loop, sel_snd, busy;

  seq_pattern_scheduler_if #(.ADDR_W(4), .DATA_W(8)) cpu_if ();

  assign cpu_if.sel     = b_sel;
  assign cpu_if.we      = b_we;
  assign cpu_if.addr    = b_addr;
  assign cpu_if.data_in = b_din;

  seq_pattern_scheduler #(.N_SLOTS(8), .DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (cpu_if),
    .bar_tick    (tick_in),
    .pattern_out (pattern_out),
    .cfg_code    (cfg_code),
    .sel_loop    (sel_loop),
    .sel_snd     (sel_snd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pat [8];
  logic       m_run, m_loop;
  int         m_len, m_idx;
  logic [7:0] m_tempo, m_pitch;
  logic [7:0] exp_pout, exp_dout;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
    m_run = 0; m_loop = 0; m_len = 0; m_idx = 0;
    m_tempo = 0; m_pitch = 0; exp_pout = 0; exp_dout = 0;
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a < 8) return m_pat[a];
    case (a)
      8:  return {6'b0, m_loop, m_run};
      9:  return 8'(m_len);
      10: return m_tempo;
      11: return m_pitch;
      12: return {m_run, 3'(m_idx), 4'b0000};  // only read while no update is in flight
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update();
    int a;
    a = int'(b_addr);
    exp_pout = m_run ? m_pat[m_idx] : 8'h00;
    if (b_sel && !b_we) exp_dout = model_read(a);
    if (b_sel && b_we && a == 8) begin
      if (b_din[0] && !m_run) m_idx = 0;
      m_run  = b_din[0];
      m_loop = b_din[1];
    end else if (tick_in && m_run) begin
      if (m_idx < m_len) m_idx = m_idx + 1;
      else begin
        m_idx = 0;
        if (!m_loop) m_run = 0;
      end
    end
    if (b_sel && b_we) begin
      if (a < 8)   m_pat[a] = b_din;
      if (a == 9)  m_len    = int'(b_din[2:0]);
      if (a == 10) m_tempo  = {5'b0, b_din[2:0]};
      if (a == 11) m_pitch  = {4'b0, b_din[3:0]};
    end
  endtask

  // ---------------- strobe monitor ----------------
  int         ev_kind[$];
  int         ev_code[$];
  int         ev_cyc[$];
  logic       prev_strobe = 1'b0;
  logic [7:0] prev_cfg = 8'h00;
  logic [7:0] held_cfg = 8'h00;
  bit         after_chk = 0;

  always @(negedge clk) begin
    if (rst) begin
      after_chk   = 0;
      prev_strobe = 1'b0;
      prev_cfg    = cfg_code;
    end else begin
      if (after_chk) begin
        check_val("cfg_hold_after_strobe", 32'(cfg_code), 32'(held_cfg));
        after_chk = 0;
      end
      if (sel_loop || sel_snd) begin
        check_val("strobe_exclusive", 32'(sel_loop & sel_snd), 0);
        if (!prev_strobe) begin
          check_val("cfg_stable_before_strobe", 32'(cfg_code), 32'(prev_cfg));
          ev_kind.push_back(sel_snd ? 1 : 0);
          ev_code.push_back(int'(cfg_code));
          ev_cyc.push_back(cyc);
        end
        held_cfg  = cfg_code;
        after_chk = 1;
      end
      prev_strobe = sel_loop | sel_snd;
      prev_cfg    = cfg_code;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (!rst) model_update();
    #1;
    check_val("pattern_out", 32'(pattern_out), 32'(exp_pout));
    check_val("data_out", 32'(cpu_if.data_out), 32'(exp_dout));
  endtask

  task automatic cpu_wr(input int a, input logic [7:0] d);
    b_sel = 1; b_we = 1; b_addr = 4'(a); b_din = d;
    step();
    b_sel = 0; b_we = 0;
  endtask

  task automatic cpu_rd(input int a);
    b_sel = 1; b_we = 0; b_addr = 4'(a);
    step();
    b_sel = 0;
  endtask

  task automatic bar();
    tick_in = 1;
    step();
    tick_in = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check_val("busy_clears", 32'(busy), 0);
  endtask

  // Issue one config burst from idle and compare the strobes seen with the
  // ordering/latest-value rules: tempo before pitch when both are pending at
  // pick time, a write inside a running update produces a second update.
  task automatic run_burst(input int typ, input logic [7:0] x, input logic [7:0] y);
    int ek[$];
    int ec[$];
    int w_cyc;
    ev_kind.delete(); ev_code.delete(); ev_cyc.delete();
    case (typ)
      0: begin cpu_wr(10, x); ek = '{0}; ec = '{int'(x & 8'h07)}; end
      1: begin cpu_wr(11, x); ek = '{1}; ec = '{int'(x & 8'h0f)}; end
      2: begin cpu_wr(10, x); w_cyc = cyc; cpu_wr(11, y); ek = '{0, 1}; ec = '{int'(x & 8'h07), int'(y & 8'h0f)}; end
      3: begin cpu_wr(10, x); w_cyc = cyc; cpu_wr(10, y); ek = '{0};    ec = '{int'(y & 8'h07)}; end
      4: begin cpu_wr(11, x); w_cyc = cyc; cpu_wr(10, y); ek = '{1, 0}; ec = '{int'(x & 8'h0f), int'(y & 8'h07)}; end
      default: begin cpu_wr(10, x); w_cyc = cyc; step(); cpu_wr(10, y); ek = '{0, 0}; ec = '{int'(x & 8'h07), int'(y & 8'h07)}; end
    endcase
    if (typ <= 1) w_cyc = cyc;
    check_val("busy_after_write", 32'(busy), 1);
    wait_idle();
    idle(2);
    check_val("strobe_count", 32'(ev_kind.size()), 32'(ek.size()));
    for (int i = 0; i < ek.size() && i < ev_kind.size(); i++) begin
      check_val("strobe_kind", 32'(ev_kind[i]), 32'(ek[i]));
      check_val("strobe_code", 32'(ev_code[i]), 32'(ec[i]));
    end
    if (ev_cyc.size() >= 1) check_val("first_strobe_latency", 32'(ev_cyc[0] - w_cyc), 2);
    if (ev_cyc.size() >= 2 && ek.size() >= 2)
      check_val("second_strobe_gap", 32'(ev_cyc[1] - ev_cyc[0]), 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a;
    int         n;
    logic [7:0] x, y;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    check_val("rst_pattern_out", 32'(pattern_out), 0);
    check_val("rst_cfg_code", 32'(cfg_code), 0);
    check_val("rst_sel_loop", 32'(sel_loop), 0);
    check_val("rst_sel_snd", 32'(sel_snd), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_data_out", 32'(cpu_if.data_out), 0);
    cpu_rd(12);
    check_val("rst_status", 32'(cpu_if.data_out), 32'h00);

    // Looping playback over slots 0..1
    cpu_wr(0, 8'h81); cpu_wr(1, 8'h42); cpu_wr(9, 8'h01); cpu_wr(8, 8'h03);
    step(); check_val("loop_play0", 32'(pattern_out), 32'h81);
    bar();  step(); check_val("loop_play1", 32'(pattern_out), 32'h42);
    bar();  step(); check_val("loop_play2", 32'(pattern_out), 32'h81);
    bar();  step(); check_val("loop_play3", 32'(pattern_out), 32'h42);

    // One-shot playback stops after slot LEN
    cpu_wr(8, 8'h00); cpu_wr(8, 8'h01);
    step(); check_val("once_play0", 32'(pattern_out), 32'h81);
    bar();  step(); check_val("once_play1", 32'(pattern_out), 32'h42);
    bar();  step(); check_val("once_stopped", 32'(pattern_out), 32'h00);
    cpu_rd(8); check_val("once_ctrl_rd", 32'(cpu_if.data_out), 32'h00);

    // Tempo/pitch serialisation and latest-value-wins
    run_burst(2, 8'h05, 8'h09);
    run_burst(3, 8'h02, 8'h06);
    cpu_rd(10); check_val("tempo_rd", 32'(cpu_if.data_out), 32'h06);
    cpu_rd(11); check_val("pitch_rd", 32'(cpu_if.data_out), 32'h09);

    // Random playback traffic against the model
    for (int i = 0; i < 8; i++) cpu_wr(i, 8'($urandom));
    cpu_wr(9, 8'($urandom_range(0, 7)));
    cpu_wr(8, 8'h03);
    for (int i = 0; i < 400; i++) begin
      tick_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 15);
        if (a == 10 || a == 11) a = 12;
        b_sel = 1; b_we = 1'($urandom); b_addr = 4'(a); b_din = 8'($urandom);
        if (a == 8) b_din[0] = ($urandom_range(0, 3) != 0);
      end
      step();
      b_sel = 0; b_we = 0; tick_in = 0;
    end
    cpu_rd(12);

    // Random config bursts
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run_burst($urandom_range(0, 5), x, y);
    end

    // Reset while a strobe is high
    ev_kind.delete(); ev_code.delete(); ev_cyc.delete();
    cpu_wr(10, 8'h03);
    n = 0;
    while (!sel_loop && n < 8) begin
      step();
      n++;
    end
    check_val("strobe_reached", 32'(sel_loop), 1);
    #2 rst = 1;
    #1;
    check_val("rst_async_sel_loop", 32'(sel_loop), 0);
    check_val("rst_async_busy", 32'(busy), 0);
    check_val("rst_async_cfg", 32'(cfg_code), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    idle(10);
    check_val("post_rst_busy", 32'(busy), 0);
    check_val("post_rst_no_strobe", 32'(ev_kind.size()), 0);
    cpu_rd(12);
    check_val("post_rst_status", 32'(cpu_if.data_out), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
